// File: rtl/ps2_scancode_decoder_if.sv
// PS/2 decoder bus: upstream frame handoff plus decoded key/error outputs.
interface ps2_scancode_decoder_if #(
    parameter int N = 11
);
    logic         full;
    logic [N-1:0] q;
    logic         frame_clr;
    logic [7:0]   key_code;
    logic         key_break;
    logic         key_ext;
    logic         key_valid;
    logic         frame_err;
    logic [7:0]   err_count;

    // Frame source / key consumer side
    modport master (
        output full, q,
        input  frame_clr, key_code, key_break, key_ext, key_valid, frame_err, err_count
    );

    // Decoder side
    modport slave (
        input  full, q,
        output frame_clr, key_code, key_break, key_ext, key_valid, frame_err, err_count
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scancode decoder: validates an 11-bit frame, tracks E0/F0 prefixes
// and emits one key strobe per complete scancode sequence.
module ps2_scancode_decoder #(
    parameter int N           = 11,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     reset,
    ps2_scancode_decoder_if.slave    bus
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, CHECK, CLR} state_t;

    state_t         state_q, state_d;
    logic           full_prev_q, full_prev_d;
    logic [N-1:0]   frame_q, frame_d;
    logic           frame_clr_q, frame_clr_d;
    logic [7:0]     key_code_q, key_code_d;
    logic           key_break_q, key_break_d;
    logic           key_ext_q, key_ext_d;
    logic           key_valid_q, key_valid_d;
    logic           frame_err_q, frame_err_d;
    logic [7:0]     err_count_q, err_count_d;
    logic           brk_pend_q, brk_pend_d;
    logic           ext_pend_q, ext_pend_d;
    logic [TW-1:0]  tmo_q, tmo_d;

    logic [7:0]     data_byte;
    logic           frame_ok;

    // Data bits arrive LSB first, so d0 sits just below the start bit.
    always_comb begin
        data_byte = '0;
        for (int i = 0; i < 8; i++) data_byte[i] = frame_q[N-2-i];
        frame_ok = !frame_q[N-1] && frame_q[0] && (^frame_q[N-2:1]);
    end

    // Next-state logic: frame latch, decode, prefix tracking and prefix timeout.
    always_comb begin
        state_d     = state_q;
        full_prev_d = bus.full;
        frame_d     = frame_q;
        frame_clr_d = frame_clr_q;
        key_code_d  = key_code_q;
        key_break_d = key_break_q;
        key_ext_d   = key_ext_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;
        brk_pend_d  = brk_pend_q;
        ext_pend_d  = ext_pend_q;
        tmo_d       = tmo_q;
        case (state_q)
            IDLE: begin
                // Only a rising full starts a frame; a stuck-high full is ignored.
                if (bus.full && !full_prev_q) begin
                    frame_d = bus.q;
                    tmo_d   = '0;
                    state_d = CHECK;
                end else if (brk_pend_q || ext_pend_q) begin
                    // Stale prefix with no follow-up code is silently dropped.
                    if (tmo_q == TMO_LAST) begin
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                        tmo_d      = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d     = CLR;
                frame_clr_d = 1'b1;
                if (!frame_ok) begin
                    frame_err_d = 1'b1;
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                    brk_pend_d  = 1'b0;
                    ext_pend_d  = 1'b0;
                end else if (data_byte == 8'hE0) begin
                    ext_pend_d = 1'b1;
                end else if (data_byte == 8'hF0) begin
                    brk_pend_d = 1'b1;
                end else begin
                    key_code_d  = data_byte;
                    key_break_d = brk_pend_q;
                    key_ext_d   = ext_pend_q;
                    key_valid_d = 1'b1;
                    brk_pend_d  = 1'b0;
                    ext_pend_d  = 1'b0;
                end
            end
            CLR: begin
                // Hold the clear request until upstream has dropped full.
                if (!bus.full) begin
                    frame_clr_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                frame_clr_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            full_prev_q <= 1'b0;
            frame_q     <= '0;
            frame_clr_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= 8'h00;
            brk_pend_q  <= 1'b0;
            ext_pend_q  <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            full_prev_q <= full_prev_d;
            frame_q     <= frame_d;
            frame_clr_q <= frame_clr_d;
            key_code_q  <= key_code_d;
            key_break_q <= key_break_d;
            key_ext_q   <= key_ext_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
            brk_pend_q  <= brk_pend_d;
            ext_pend_q  <= ext_pend_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.frame_clr = frame_clr_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_break = key_break_q;
    assign bus.key_ext   = key_ext_q;
    assign bus.key_valid = key_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_count_q;
endmodule
